// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: a 2-entry fetch queue whose head is decoded
// into a registered RV32 bundle for execute, plus flush and back-pressure count.
module decode_issue_ctrl #(
  parameter int INST_WIDTH = 32,
  parameter int IMM_WIDTH  = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [INST_WIDTH-1:0] if_inst,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_ready,
  input  logic                  flush,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [IMM_WIDTH-1:0]  id_imm,
  output logic [2:0]            id_type,
  output logic                  id_illegal,
  output logic [15:0]           stall_cnt
);

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_U = 3'd2;
  localparam logic [2:0] TYPE_J = 3'd3;
  localparam logic [2:0] TYPE_B = 3'd4;
  localparam logic [2:0] TYPE_S = 3'd5;

  // Returns {illegal, type}; unsupported opcodes fall back to type R.
  function automatic logic [3:0] decode_op(input logic [6:0] op);
    case (op)
      7'b0110011:                         return {1'b0, TYPE_R};
      7'b0010011, 7'b1100111, 7'b0000011: return {1'b0, TYPE_I};
      7'b0010111, 7'b0110111:             return {1'b0, TYPE_U};
      7'b1101111:                         return {1'b0, TYPE_J};
      7'b1100011:                         return {1'b0, TYPE_B};
      7'b0100011:                         return {1'b0, TYPE_S};
      default:                            return {1'b1, TYPE_R};
    endcase
  endfunction

  function automatic logic [IMM_WIDTH-1:0] gen_imm(input logic [INST_WIDTH-1:0] inst,
                                                   input logic [2:0] typ);
    logic s;
    s = inst[31];
    case (typ)
      TYPE_I:  return {{20{s}}, inst[31:20]};
      TYPE_U:  return {inst[31:12], 12'b0};
      TYPE_J:  return {{11{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0};
      TYPE_B:  return {{19{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};
      TYPE_S:  return {{20{s}}, inst[31:25], inst[11:7]};
      default: return {IMM_WIDTH{1'b0}};
    endcase
  endfunction

  logic [INST_WIDTH-1:0] mem_inst_q [2];
  logic [INST_WIDTH-1:0] mem_inst_d [2];
  logic [PC_WIDTH-1:0]   mem_pc_q [2];
  logic [PC_WIDTH-1:0]   mem_pc_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  id_valid_q, id_valid_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
  logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [IMM_WIDTH-1:0]  id_imm_q, id_imm_d;
  logic [2:0]            id_type_q, id_type_d;
  logic                  id_illegal_q, id_illegal_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  logic                  push;
  logic                  load;
  logic [INST_WIDTH-1:0] head_inst;
  logic [3:0]            head_dec;

  // Acceptance never looks at id_ready, so fetch is decoupled from execute.
  assign if_ready  = (count_q != 2'd2) && !flush;
  assign push      = if_valid && if_ready;
  assign load      = !flush && (count_q != 2'd0) && (!id_valid_q || id_ready);
  assign head_inst = mem_inst_q[rd_ptr_q];
  assign head_dec  = decode_op(head_inst[6:0]);

  // Next-state for queue, decode bundle and back-pressure counter.
  always_comb begin
    mem_inst_d   = mem_inst_q;
    mem_pc_d     = mem_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    id_valid_d   = id_valid_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    id_imm_d     = id_imm_q;
    id_type_d    = id_type_q;
    id_illegal_d = id_illegal_q;
    stall_cnt_d  = stall_cnt_q;

    if (flush) begin
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
      id_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_inst_d[wr_ptr_q] = if_inst;
        mem_pc_d[wr_ptr_q]   = if_pc;
        wr_ptr_d             = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (load) begin
        id_valid_d   = 1'b1;
        id_inst_d    = head_inst;
        id_pc_d      = mem_pc_q[rd_ptr_q];
        id_type_d    = head_dec[2:0];
        id_illegal_d = head_dec[3];
        id_imm_d     = gen_imm(head_inst, head_dec[2:0]);
        rd_ptr_d     = ~rd_ptr_q;
      end else if (id_valid_q && id_ready) begin
        id_valid_d = 1'b0;
      end else begin
        id_valid_d = id_valid_q;
      end

      case ({push, load})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end

    if (id_valid_q && !id_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_inst_q[i] <= {INST_WIDTH{1'b0}};
        mem_pc_q[i]   <= {PC_WIDTH{1'b0}};
      end
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      id_valid_q   <= 1'b0;
      id_inst_q    <= {INST_WIDTH{1'b0}};
      id_pc_q      <= {PC_WIDTH{1'b0}};
      id_imm_q     <= {IMM_WIDTH{1'b0}};
      id_type_q    <= 3'd0;
      id_illegal_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      mem_inst_q   <= mem_inst_d;
      mem_pc_q     <= mem_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      id_valid_q   <= id_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      id_imm_q     <= id_imm_d;
      id_type_q    <= id_type_d;
      id_illegal_q <= id_illegal_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_inst    = id_inst_q;
  assign id_pc      = id_pc_q;
  assign id_imm     = id_imm_q;
  assign id_type    = id_type_q;
  assign id_illegal = id_illegal_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Decode-stage issue controller for the RV32 core. It sits between instruction fetch and execute and buffers fetched instructions in a 2-entry queue. It sequences the queue head through an internal immediate generator and presents a registered decode bundle (instruction, PC, immediate, type, illegal flag) to execute under a valid/ready handshake. It also handles pipeline flush on redirect and counts execute back-pressure cycles.

## Interface
- inst_width, 32, instruction width
- imm_width, 32, immediate width
- pc_width, 32, PC width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_inst  in  inst_width  fetched instruction
- if_pc  in  pc_width  PC of if_inst
- if_ready  out  1  queue can accept this cycle
- flush  in  1  redirect; discard all buffered and presented instructions
- id_valid  out  1  decode bundle valid
- id_ready  in  1  execute consumes bundle
- id_inst  out  inst_width  registered instruction
- id_pc  out  pc_width  registered PC
- id_imm  out  imm_width  registered immediate, two's complement
- id_type  out  3  0 R/none, 1 I, 2 U, 3 J, 4 B, 5 S
- id_illegal  out  1  opcode not supported
- stall_cnt  out  16  saturating back-pressure cycle count

## Operation
- Queue: 2 entries {inst, pc}, 1-bit wr/rd pointers, 2-bit count 0..2.
- Push when if_valid && if_ready. if_ready = (count != 2) && !flush. It does not depend on id_ready.
- Output register load condition: load = (count != 0) && (!id_valid || id_ready). On load, pop the head and register it into id_*. Otherwise, if id_valid && id_ready, clear id_valid.
- Simultaneous push and pop: count is unchanged. A push at count 2 is impossible because if_ready is 0.
- Type decode from inst[6:0]:
  - 0110011 → 0
  - 0010011, 1100111, 0000011 → 1
  - 0010111, 0110111 → 2
  - 1101111 → 3
  - 1100011 → 4
  - 0100011 → 5
  - anything else → 0 with id_illegal=1
- Immediate, sign bit s=inst[31]:
  - type 0 → 0
  - type 1 → {20{s}, inst[31:20]}
  - type 2 → {inst[31:12], 12'b0}
  - type 3 → {11{s}, s, inst[19:12], inst[20], inst[30:21], 0}
  - type 4 → {19{s}, s, inst[7], inst[30:25], inst[11:8], 0}
  - type 5 → {20{s}, inst[31:25], inst[11:7]}
- Immediate generation is combinational on the queue head. It is captured only at load.
- stall_cnt: +1 each cycle id_valid && !id_ready, saturates at 16'hFFFF. Cleared by rst only; flush does not clear it.
- Flush: count←0, pointers←0, id_valid←0. Push, pop and load are suppressed in that cycle. id_inst/id_pc/id_imm/id_type/id_illegal hold their previous values; they are don't-care while id_valid=0.
- Priority: rst > flush > normal operation.

## Timing
- Reset values:
  - if_ready=1, id_valid=0, stall_cnt=0.
  - count and pointers 0.
  - id_inst, id_pc, id_imm, id_type, id_illegal all 0.
- Latency: a push at edge N is loaded at edge N+1, so id_valid=1 after N+1. That is 2 edges from presentation to id_valid.
- Throughput: 1 instruction per cycle sustained, with count settling at 1.
- Back-pressure: while id_valid && !id_ready, the id_* outputs are stable. The queue fills to 2, then if_ready drops in the cycle after count reaches 2.
- Once id_valid=1, it stays high until id_ready or flush.
- Order: instructions appear on id_* in push order. There is no loss or duplication across pointer wrap.
- rst asserted mid-stream: all state returns to reset values at that edge. Pushes in that cycle are discarded.
- flush with if_valid=1 in the same cycle: the instruction is not accepted (if_ready=0).

## Test plan
- Stream 0xFFF00093, 0x123450B7, 0xFFDFF06F, 0x00000463, 0x00112223 with id_ready=1 → types 1,2,3,4,5 and imm 0xFFFFFFFF, 0x12345000, 0xFFFFFFFC, 0x00000008, 0x00000004. One bundle per cycle after 2-edge latency.
- id_ready=0 for 6 cycles while streaming → 1 bundle held stable, count=2, if_ready=0, stall_cnt=6. Release → remaining bundles drain in order, none lost.
- flush asserted with count=2 and id_valid=1 → next cycle id_valid=0, if_ready=1. The next pushed instruction appears 2 edges later.
- Opcode 0x7F (0x0000007F) → id_illegal=1, id_type=0, id_imm=0. 0x00208033 (add) → id_illegal=0, id_type=0.
- Hold id_valid with id_ready=0 for 70000 cycles → stall_cnt saturates at 0xFFFF. flush leaves it unchanged; rst zeroes it.
- rst pulsed mid-stream with count=1 → all outputs at reset values next cycle, and no stale bundle appears afterward.
